// File: rtl/enigma_feeder.sv
// -----------------------------------------------------------------------------
// enigma_feeder
//   Front-end for the enigma core. Filters an ASCII byte stream down to
//   letters, folds case to letter codes 1..26, queues them in a FIFO and,
//   on each pop, maps them through a reconfigurable plugboard before issuing
//   them one at a time to the core.
//
// Ports
//   clk_in, rst_n_in        clock, asynchronous active-low reset
//   ascii_valid_in/ascii_in byte strobe and byte
//   ascii_ready_out         high while the FIFO is not full
//   plug_valid_in           plugboard pair write (plug_a_in, plug_b_in)
//   plug_clear_in           restore identity plugboard (wins over a write)
//   enc_cfg_in              core reconfiguration; aborts the letter in flight
//   enc_ready_in            core ready
//   enc_valid_out           one-cycle letter strobe to the core
//   enc_data_out            plugboard-mapped letter code 1..26
//   fifo_count_out          FIFO occupancy
//   drop_count_out          discarded non-letter bytes, saturating at 255
//   dbg_state_out           issue FSM state (0 idle, 1 hold, 2 wait)
//
// Handshake: a byte moves when ascii_valid_in && ascii_ready_out are both high
// in the same cycle. A letter is offered to the core only when enc_ready_in is
// high in the IDLE state; enc_valid_out is then high for exactly one cycle.
// -----------------------------------------------------------------------------
module enigma_feeder #(
    parameter int DEPTH = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     ascii_valid_in,
    input  logic [7:0]               ascii_in,
    output logic                     ascii_ready_out,
    input  logic                     plug_valid_in,
    input  logic [4:0]               plug_a_in,
    input  logic [4:0]               plug_b_in,
    input  logic                     plug_clear_in,
    input  logic                     enc_cfg_in,
    input  logic                     enc_ready_in,
    output logic                     enc_valid_out,
    output logic [4:0]               enc_data_out,
    output logic [$clog2(DEPTH):0]   fifo_count_out,
    output logic [7:0]               drop_count_out,
    output logic [1:0]               dbg_state_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [4:0]      r_mem [0:DEPTH-1];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [7:0]      r_drop;
    logic            r_valid;
    logic [4:0]      r_data;
    logic            r_cfg_d;
    logic [4:0]      r_map [1:26];
    logic [4:0]      w_map_nxt [1:26];
    logic [4:0]      w_pa;
    logic [4:0]      w_pb;

    logic w_full, w_empty, w_is_letter, w_accept, w_push, w_drop, w_pop;
    logic w_plug_ok;

    // ---------------- input filter ----------------
    // 'A'..'Z' and 'a'..'z' both carry the letter code 1..26 in bits [4:0].
    assign w_is_letter = ((ascii_in >= 8'h41) && (ascii_in <= 8'h5A)) ||
                         ((ascii_in >= 8'h61) && (ascii_in <= 8'h7A));
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_accept    = ascii_valid_in && !w_full;
    assign w_push      = w_accept && w_is_letter;
    assign w_drop      = w_accept && !w_is_letter;

    // No pop during an abort or in the cycle right after it.
    assign w_pop = (r_state == S_IDLE) && !w_empty && enc_ready_in &&
                   !enc_cfg_in && !r_cfg_d;

    // ---------------- FIFO ----------------
    always_ff @(posedge clk_in) begin
        if (w_push) r_mem[r_wr_ptr] <= ascii_in[4:0];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_drop   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
        end
    end

    // ---------------- plugboard ----------------
    // Both letters of a write drop their old partners back to identity before
    // the new pair is formed; a==b therefore just unpairs the letter.
    assign w_plug_ok = plug_valid_in &&
                       (plug_a_in >= 5'd1) && (plug_a_in <= 5'd26) &&
                       (plug_b_in >= 5'd1) && (plug_b_in <= 5'd26);

    always_comb begin
        w_map_nxt = r_map;
        w_pa      = 5'd0;
        w_pb      = 5'd0;
        if (plug_clear_in) begin
            for (int i = 1; i <= 26; i++) w_map_nxt[i] = 5'(i);
        end else if (w_plug_ok) begin
            w_pa = r_map[plug_a_in];
            w_pb = r_map[plug_b_in];
            w_map_nxt[w_pa]      = w_pa;
            w_map_nxt[w_pb]      = w_pb;
            w_map_nxt[plug_a_in] = plug_b_in;
            w_map_nxt[plug_b_in] = plug_a_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 1; i <= 26; i++) r_map[i] <= 5'(i);
        end else begin
            r_map <= w_map_nxt;
        end
    end

    // ---------------- issue FSM ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (enc_cfg_in) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_pop) w_state_nxt = S_HOLD;
                // HOLD covers the cycle in which the core's ready is still stale.
                S_HOLD:  w_state_nxt = S_WAIT;
                S_WAIT:  if (enc_ready_in) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_data  <= 5'd0;
            r_cfg_d <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_pop;
            r_cfg_d <= enc_cfg_in;
            // The table as it stands at pop time is the one applied.
            if (w_pop) r_data <= r_map[r_mem[r_rd_ptr]];
        end
    end

    assign ascii_ready_out = !w_full;
    assign enc_valid_out   = r_valid;
    assign enc_data_out    = r_data;
    assign fifo_count_out  = r_count;
    assign drop_count_out  = r_drop;
    assign dbg_state_out   = r_state;

endmodule

// File: tb/tb_enigma_feeder.sv
module tb_enigma_feeder;

  localparam int DEPTH = 16;
  localparam int ST_IDLE = 0;
  localparam int ST_WAIT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic                   ascii_valid = 1'b0;
  logic [7:0]             ascii_data = 8'h00;
  logic                   ascii_ready_out;
  logic                   plug_valid = 1'b0;
  logic [4:0]             plug_a = 5'd0;
  logic [4:0]             plug_b = 5'd0;
  logic                   plug_clear = 1'b0;
  logic                   enc_cfg = 1'b0;
  logic                   tb_ready = 1'b0;
  logic                   core_ready = 1'b1;
  logic                   core_mode = 1'b0;
  logic                   enc_ready;
  logic                   enc_valid_out;
  logic [4:0]             enc_data_out;
  logic [$clog2(DEPTH):0] fifo_count_out;
  logic [7:0]             drop_count_out;
  logic [1:0]             dbg_state_out;

  assign enc_ready = core_mode ? core_ready : tb_ready;

  enigma_feeder #(.DEPTH(DEPTH)) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .ascii_valid_in  (ascii_valid),
    .ascii_in        (ascii_data),
    .ascii_ready_out (ascii_ready_out),
    .plug_valid_in   (plug_valid),
    .plug_a_in       (plug_a),
    .plug_b_in       (plug_b),
    .plug_clear_in   (plug_clear),
    .enc_cfg_in      (enc_cfg),
    .enc_ready_in    (enc_ready),
    .enc_valid_out   (enc_valid_out),
    .enc_data_out    (enc_data_out),
    .fifo_count_out  (fifo_count_out),
    .drop_count_out  (drop_count_out),
    .dbg_state_out   (dbg_state_out)
  );

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model ----------------
  // Letters waiting to be seen at the core (pre-plugboard code), plugboard
  // partner table, and the expected drop count.
  logic [4:0] exp_q[$];
  int         pmap[27];
  int         drop_exp = 0;

  function automatic int letter_code(input logic [7:0] b);
    if (b >= 8'h41 && b <= 8'h5A) return int'(b) - 'h40;
    if (b >= 8'h61 && b <= 8'h7A) return int'(b) - 'h60;
    return 0;
  endfunction

  task automatic model_identity();
    for (int i = 0; i < 27; i++) pmap[i] = i;
  endtask

  task automatic model_unpair(input int x);
    int p;
    p = pmap[x];
    pmap[p] = p;
    pmap[x] = x;
  endtask

  task automatic model_plug(input int a, input int b);
    if (a < 1 || a > 26 || b < 1 || b > 26) return;
    model_unpair(a);
    model_unpair(b);
    if (a != b) begin
      pmap[a] = b;
      pmap[b] = a;
    end
  endtask

  task automatic model_accept(input logic [7:0] b);
    int c;
    c = letter_code(b);
    if (c != 0) exp_q.push_back(5'(c));
    else if (drop_exp < 255) drop_exp++;
  endtask

  // ---------------- core model (ready low 6 cycles after each strobe) ----------------
  logic strobe_seen = 1'b0;
  int   busy = 0;
  always @(posedge clk) begin
    if (strobe_seen) busy = 6;
    else if (busy > 0) busy = busy - 1;
    #1 core_ready = (busy == 0);
  end

  // ---------------- scoreboard / monitor ----------------
  logic [4:0] got_q[$];
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  int         last_pulse_cyc = 0;
  bit         have_last = 0;
  int         first_pulse_cyc = -1;

  always @(negedge clk) begin
    int code;
    strobe_seen = enc_valid_out;
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (enc_valid_out) begin
        chk("pulse_width", int'(prev_valid), 0);
        chk("ready_at_issue", int'(prev_ready), 1);
        if (have_last && (cyc - last_pulse_cyc) < 3)
          chk("pulse_gap", cyc - last_pulse_cyc, 3);
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", int'(enc_data_out), 0);
        end else begin
          code = int'(exp_q.pop_front());
          chk("letter_data", int'(enc_data_out), pmap[code]);
        end
        got_q.push_back(enc_data_out);
        last_pulse_cyc = cyc;
        have_last = 1;
        if (first_pulse_cyc < 0) first_pulse_cyc = cyc;
      end
      prev_valid = enc_valid_out;
      prev_ready = enc_ready;
    end
  end

  // ---------------- driver tasks (start and end at posedge + 1) ----------------
  int last_acc_cyc = 0;

  task automatic send_byte(input logic [7:0] b);
    bit acc;
    acc = 0;
    ascii_valid = 1'b1;
    ascii_data  = b;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      acc = ascii_ready_out;
      last_acc_cyc = cyc;
      @(posedge clk); #1;
      if (acc) break;
    end
    ascii_valid = 1'b0;
    if (!acc) fail_now("send_timeout");
    else model_accept(b);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic plug_write(input int a, input int b);
    plug_valid = 1'b1;
    plug_a = 5'(a);
    plug_b = 5'(b);
    @(posedge clk); #1;
    plug_valid = 1'b0;
    model_plug(a, b);
  endtask

  task automatic plug_clr();
    plug_clear = 1'b1;
    @(posedge clk); #1;
    plug_clear = 1'b0;
    model_identity();
  endtask

  task automatic wait_drain(input int max);
    bit ok;
    ok = 0;
    for (int t = 0; t < max; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && fifo_count_out == 0 && !enc_valid_out) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("drain");
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_pulse(input int max, output int pc);
    bit ok;
    ok = 0;
    pc = -1;
    for (int t = 0; t < max; t++) begin
      @(negedge clk);
      if (enc_valid_out) begin
        ok = 1;
        pc = cyc;
        break;
      end
    end
    if (!ok) fail_now("wait_pulse");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    model_identity();
    drop_exp = 0;
    have_last = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- table of filter vectors ----------------
  typedef struct {
    logic [7:0] b;
    logic [4:0] code;
    bit         drop;
  } vec_t;

  vec_t tbl[10];

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int pc;
    int cfg_cyc;
    int d0;
    int acc_h;
    logic [7:0] rb;

    tbl[0] = '{8'h40, 5'd0,  1'b1};
    tbl[1] = '{8'h41, 5'd1,  1'b0};
    tbl[2] = '{8'h5A, 5'd26, 1'b0};
    tbl[3] = '{8'h5B, 5'd0,  1'b1};
    tbl[4] = '{8'h60, 5'd0,  1'b1};
    tbl[5] = '{8'h61, 5'd1,  1'b0};
    tbl[6] = '{8'h7A, 5'd26, 1'b0};
    tbl[7] = '{8'h7B, 5'd0,  1'b1};
    tbl[8] = '{8'h00, 5'd0,  1'b1};
    tbl[9] = '{8'hC1, 5'd0,  1'b1};

    do_reset();

    // Reset values
    @(negedge clk);
    chk("rst_valid", int'(enc_valid_out), 0);
    chk("rst_data", int'(enc_data_out), 0);
    chk("rst_ready", int'(ascii_ready_out), 1);
    chk("rst_count", int'(fifo_count_out), 0);
    chk("rst_drop", int'(drop_count_out), 0);
    chk("rst_state", int'(dbg_state_out), ST_IDLE);
    @(posedge clk); #1;

    // Filter and fold: "Hi!z"
    tb_ready = 1'b1;
    got_q.delete();
    first_pulse_cyc = -1;
    send_byte("H");
    acc_h = last_acc_cyc;
    send_str("i!z");
    wait_drain(100);
    chk("hiz_latency", first_pulse_cyc - acc_h, 2);
    chk("hiz_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("hiz_0", int'(got_q[0]), 8);
      chk("hiz_1", int'(got_q[1]), 9);
      chk("hiz_2", int'(got_q[2]), 26);
    end
    chk("hiz_drop", int'(drop_count_out), 1);

    // Table-driven filter boundaries
    foreach (tbl[i]) begin
      d0 = int'(drop_count_out);
      got_q.delete();
      send_byte(tbl[i].b);
      wait_drain(50);
      chk("tbl_drop_delta", int'(drop_count_out) - d0, int'(tbl[i].drop));
      chk("tbl_pulses", got_q.size(), tbl[i].drop ? 0 : 1);
      if (!tbl[i].drop && got_q.size() == 1) chk("tbl_code", int'(got_q[0]), int'(tbl[i].code));
    end

    // Plugboard: (1,2) then (2,3), "ABC" -> 1,3,2
    got_q.delete();
    plug_write(1, 2);
    plug_write(2, 3);
    send_str("ABC");
    wait_drain(100);
    chk("plug_n", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("plug_0", int'(got_q[0]), 1);
      chk("plug_1", int'(got_q[1]), 3);
      chk("plug_2", int'(got_q[2]), 2);
    end
    got_q.delete();
    plug_clr();
    send_str("B");
    plug_write(0, 5);
    plug_write(27, 5);
    send_str("E");
    plug_write(4, 9);
    plug_write(4, 4);
    send_str("DI");
    wait_drain(100);
    chk("plug2_n", got_q.size(), 4);
    if (got_q.size() == 4) begin
      chk("clear_b", int'(got_q[0]), 2);
      chk("ignored_e", int'(got_q[1]), 5);
      chk("unpair_d", int'(got_q[2]), 4);
      chk("unpair_i", int'(got_q[3]), 9);
    end

    // Randomized plugboard writes and byte streams against the model
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 9) == 0) plug_clr();
      else plug_write($urandom_range(0, 28), $urandom_range(0, 28));
      for (int k = 0; k < $urandom_range(1, 5); k++) begin
        rb = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(8'h40, 8'h7F));
        send_byte(rb);
      end
      wait_drain(200);
    end
    chk("rand_drop", int'(drop_count_out), drop_exp);
    plug_clr();

    // Handshake against the core model
    got_q.delete();
    core_mode = 1'b1;
    send_str("QWERT");
    wait_drain(300);
    chk("hs_count", got_q.size(), 5);
    core_mode = 1'b0;
    tb_ready = 1'b1;

    // Full FIFO: DEPTH+3 letters with ready low
    tb_ready = 1'b0;
    got_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      send_byte(8'($urandom_range(8'h41, 8'h5A)));
      chk("fill_count", int'(fifo_count_out), i + 1);
      chk("fill_ready", int'(ascii_ready_out), (i + 1 < DEPTH) ? 1 : 0);
    end
    fork
      begin
        for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(8'h61, 8'h7A)));
      end
      begin
        repeat (8) @(negedge clk);
        chk("full_held_ready", int'(ascii_ready_out), 0);
        chk("full_held_count", int'(fifo_count_out), DEPTH);
        @(posedge clk); #1;
        tb_ready = 1'b1;
      end
    join
    wait_drain(400);
    chk("full_total", got_q.size(), DEPTH + 3);

    // Abort while in WAIT
    tb_ready = 1'b1;
    send_str("K");
    wait_pulse(20, pc);
    @(posedge clk); #1;
    tb_ready = 1'b0;
    send_str("MN");
    @(negedge clk);
    chk("abort_in_wait", int'(dbg_state_out), ST_WAIT);
    chk("abort_pre_count", int'(fifo_count_out), 2);
    @(posedge clk); #1;
    enc_cfg  = 1'b1;
    tb_ready = 1'b1;
    cfg_cyc  = cyc;
    @(negedge clk);
    chk("abort_cfg_valid", int'(enc_valid_out), 0);
    @(posedge clk); #1;
    enc_cfg = 1'b0;
    @(negedge clk);
    chk("abort_state", int'(dbg_state_out), ST_IDLE);
    @(negedge clk);
    chk("abort_count_kept", int'(fifo_count_out), 2);
    chk("abort_no_issue", int'(enc_valid_out), 0);
    wait_pulse(20, pc);
    chk("abort_resume_cyc", pc - cfg_cyc, 3);
    @(posedge clk); #1;
    wait_drain(100);

    // Reset mid-pulse, with a pair in the plugboard and letters queued
    plug_write(26, 1);
    tb_ready = 1'b0;
    send_str("AZY");
    tb_ready = 1'b1;
    wait_pulse(20, pc);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    model_identity();
    drop_exp = 0;
    have_last = 0;
    #1;
    chk("mid_rst_valid", int'(enc_valid_out), 0);
    chk("mid_rst_data", int'(enc_data_out), 0);
    chk("mid_rst_count", int'(fifo_count_out), 0);
    chk("mid_rst_ready", int'(ascii_ready_out), 1);
    chk("mid_rst_drop", int'(drop_count_out), 0);
    chk("mid_rst_state", int'(dbg_state_out), ST_IDLE);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    got_q.delete();
    send_str("Z");
    wait_drain(50);
    chk("post_rst_n", got_q.size(), 1);
    if (got_q.size() == 1) chk("post_rst_identity", int'(got_q[0]), 26);

    // Drop saturation
    for (int i = 0; i < 300; i++) begin
      do rb = 8'($urandom_range(0, 255)); while (letter_code(rb) != 0);
      send_byte(rb);
    end
    @(negedge clk);
    chk("drop_sat", int'(drop_count_out), 255);
    chk("drop_model", int'(drop_count_out), drop_exp);
    chk("drop_no_letters", int'(fifo_count_out), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/enigma_feeder.md
# enigma_feeder

Upstream front-end for the `enigma` core. It accepts an ASCII byte stream and discards non-letters. Letters are case-folded to the core's 1..26 letter code (A=1 … Z=26), buffered in a FIFO, and passed through a configurable plugboard. The result is issued to the core one letter at a time using the core's `ready` / `data_valid_in` handshake.

## Interface
Parameters:
- DEPTH, 16, letter FIFO depth (power of two, ≥2)

Ports (one clock; reset is asynchronous and active-low):
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous active-low reset
- ascii_valid_in  input  1  byte strobe
- ascii_in  input  8  ASCII byte
- ascii_ready_out  output  1  high when the FIFO is not full (= !full)
- plug_valid_in  input  1  plugboard pair write strobe
- plug_a_in, plug_b_in  input  5 each  letter codes of the pair
- plug_clear_in  input  1  restore identity plugboard
- enc_cfg_in  input  1  mirrors the core's `rotor_valid_in`; aborts any letter in flight
- enc_ready_in  input  1  core `ready`
- enc_valid_out  output  1  core `data_valid_in`
- enc_data_out  output  5  core `data_in`, letter code 1..26
- fifo_count_out  output  $clog2(DEPTH)+1  FIFO occupancy
- drop_count_out  output  8  non-letter bytes discarded, saturating at 255

## Operation
- **Filter:** bytes 0x41–0x5A map to code byte−0x40; bytes 0x61–0x7A map to code byte−0x60. All other bytes are dropped and increment drop_count_out.
- **Input acceptance:** a byte is consumed only when ascii_valid_in=1 and ascii_ready_out=1. A letter that is consumed but cannot be stored does not exist, because a letter is only consumed when the FIFO has space.
- **Plugboard:** a 26-entry table `map[c]`, identity after reset.
  - Write pair (a,b), with a≠b and both in 1..26: any previous partner of a and any previous partner of b is first restored to identity, then map[a]=b and map[b]=a.
  - a==b: unpairs a, restoring a and its old partner to identity.
  - Any code of 0 or >26: the write is ignored.
  - plug_clear_in has priority over plug_valid_in in the same cycle.
  - The number of pairs is unlimited, at most 13 by construction.
- **Plugboard timing:** the plugboard is applied at FIFO pop. A table write in cycle N affects only pops in cycle N+1 or later.
- **FSM:**
  - IDLE: if the FIFO is not empty and enc_ready_in=1, register enc_valid_out=1 and enc_data_out=map[head], pop, go to HOLD.
  - HOLD: register enc_valid_out=0, go to WAIT.
  - WAIT: go to IDLE when enc_ready_in=1.
- **enc_cfg_in:**
  - Any state: go to IDLE, enc_valid_out=0.
  - The popped letter is lost; FIFO contents are kept.
  - No issue occurs in the enc_cfg_in cycle or the cycle after it.

## Timing
- **Reset values:** enc_valid_out=0, enc_data_out=0, ascii_ready_out=1, fifo_count_out=0, drop_count_out=0, FSM=IDLE, plugboard=identity, FIFO empty.
- **Reset mid-operation:** takes effect immediately and asynchronously; an in-flight enc_valid_out pulse is cut.
- **enc_valid_out pulse:** exactly one cycle wide per letter.
- **Latency:** a letter written in cycle N into an empty FIFO, with the FSM idle and enc_ready_in=1, appears on enc_valid_out in cycle N+2 (one cycle FIFO write, one cycle registered issue).
- **Throughput:** at most one letter per 3 cycles. In practice the rate is bounded by the core's ready turnaround.
- **Why WAIT ignores a stale ready:** the core drops `ready` one cycle after it samples the strobe. HOLD covers that cycle, so WAIT never sees a stale ready=1.
- **Full FIFO:** ascii_ready_out=0 and bytes are not consumed. A simultaneous push and pop on a full FIFO rejects the push; the byte is accepted the following cycle.
- **Empty FIFO:** no issue. A byte written in cycle N cannot pop in cycle N.
- **Counters:** fifo_count_out is updated the same cycle as the push/pop and holds on a simultaneous push+pop. drop_count_out holds at 255.
- **FIFO pointers:** wrap modulo DEPTH.

## Test plan
- **Filter and fold:** after reset, send "Hi!z" with enc_ready_in=1.
  - enc_data_out sequence: 8, 9, 26, each a one-cycle pulse.
  - drop_count_out=1.
  - First pulse 2 cycles after 'H' is accepted.
- **Plugboard:** write pairs (1,2) then (2,3), then send "ABC".
  - Outputs: 1, 3, 2, because A is restored when B is re-paired.
  - plug_clear_in, then "B" → 2.
  - Write (0,5) → ignored.
- **Handshake:** model the core with ready low for 6 cycles after each strobe; push 5 letters back-to-back.
  - Exactly 5 pulses.
  - No pulse while ready=0 or within one cycle of the previous pulse.
  - Order preserved.
- **Full FIFO:** enc_ready_in=0, push DEPTH+3 letters.
  - ascii_ready_out falls when fifo_count_out=DEPTH.
  - Extra bytes held, not lost.
  - Raise ready: all DEPTH+3 letters eventually emitted in order.
- **Abort and reset:**
  - enc_cfg_in pulse while in WAIT → returns to IDLE; the next letter issues once ready=1; FIFO count unchanged by the abort.
  - rst_n_in low mid-pulse → enc_valid_out=0 immediately and all outputs at their reset values.
- **Drop saturation:** send 300 non-letters → drop_count_out=255.
